// File: rtl/ov5640_pkg.sv
// Shared constants and FSM encoding for the OV5640 capture path.
package ov5640_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned PIX_W   = 16;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ov5640_window_if.sv
// Pixel stream in from the 8-to-16 packer and windowed pixel stream out.
interface ov5640_window_if;
  import ov5640_pkg::*;

  logic               pix_valid;
  logic [PIX_W-1:0]   pix_data;
  logic               win_valid;
  logic [PIX_W-1:0]   win_data;
  logic               win_sof;
  logic               win_eol;
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;

  modport master (
    output pix_valid, pix_data,
    input  win_valid, win_data, win_sof, win_eol, win_x, win_y
  );

  modport slave (
    input  pix_valid, pix_data,
    output win_valid, win_data, win_sof, win_eol, win_x, win_y
  );

endinterface

// File: rtl/ov5640_edge_det.sv
// Registered rise/fall detector for a raw camera sync line.
module ov5640_edge_det #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic ov5640_pclk,
  input  logic sys_rst_n,
  input  logic sig,
  output logic rise_c,
  output logic fall_c
);

  logic sig_d;

  // Resetting high means a line already asserted at reset release is not a rise.
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) sig_d <= RST_VAL;
    else            sig_d <= sig;
  end

  assign rise_c = sig & ~sig_d;
  assign fall_c = ~sig & sig_d;

endmodule

// File: rtl/ov5640_window.sv
// Crops a WIN_W x WIN_H window out of the OV5640 RGB565 stream and tracks frames.
// Optional line statistics are built when OV5640_WINDOW_STATS_EN is defined.
module ov5640_window
  import ov5640_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned WIN_X0 = 0,
  parameter int unsigned WIN_Y0 = 0,
  parameter int unsigned WIN_W  = 320,
  parameter int unsigned WIN_H  = 240
) (
  input  logic               ov5640_pclk,
  input  logic               sys_rst_n,
  input  logic               ov5640_vsync,
  input  logic               ov5640_href,
  ov5640_window_if.slave     bus,
  output logic               frame_done,
  output logic [COORD_W-1:0] stat_lines,
  output logic               stat_err
);

  localparam logic [COORD_W-1:0] X_LO   = COORD_W'(WIN_X0);
  localparam logic [COORD_W-1:0] Y_LO   = COORD_W'(WIN_Y0);
  localparam logic [COORD_W-1:0] X_HI   = COORD_W'(WIN_X0 + WIN_W);
  localparam logic [COORD_W-1:0] Y_HI   = COORD_W'(WIN_Y0 + WIN_H);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIN_X0 + WIN_W - 1);
  localparam bit unused_cfg_ok = (WIN_X0 + WIN_W <= IMG_W) && (WIN_Y0 + WIN_H <= IMG_H);

  state_t             state, state_n;
  logic               vs_rise_c, vs_fall_c, hs_rise_c, hs_fall_c;
  logic [COORD_W-1:0] x, y, x_after_c;
  logic               first_line;
  logic               pix_take_c, in_win_c, frame_done_c;
  logic               unused_falls;

  ov5640_edge_det u_vs_det (
    .ov5640_pclk (ov5640_pclk), .sys_rst_n (sys_rst_n),
    .sig (ov5640_vsync), .rise_c (vs_rise_c), .fall_c (vs_fall_c)
  );

  ov5640_edge_det u_hs_det (
    .ov5640_pclk (ov5640_pclk), .sys_rst_n (sys_rst_n),
    .sig (ov5640_href), .rise_c (hs_rise_c), .fall_c (hs_fall_c)
  );

  // Falls are deliberately ignored: a late pixel after href drops stays in its line.
  assign unused_falls = vs_fall_c ^ hs_fall_c;

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (vs_rise_c) state_n = ST_FRAME;
      ST_FRAME: if (vs_rise_c) state_n = ST_DONE;
      ST_DONE:  state_n = ST_FRAME;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_done_c = 1'b0;
    pix_take_c   = 1'b0;
    if (state == ST_FRAME && vs_rise_c) frame_done_c = 1'b1;
    if (state != ST_IDLE && !first_line && bus.pix_valid) pix_take_c = 1'b1;
  end

  assign x_after_c = (pix_take_c && x != COORD_MAX) ? x + COORD_W'(1) : x;
  assign in_win_c  = pix_take_c && (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);

  // Current pixel always uses the pre-update counters; syncs then override.
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x          <= '0;
      y          <= '0;
      first_line <= 1'b1;
    end else if (vs_rise_c) begin
      x          <= '0;
      y          <= '0;
      first_line <= 1'b1;
    end else if (hs_rise_c && state != ST_IDLE) begin
      x <= '0;
      if (first_line) begin
        y          <= '0;
        first_line <= 1'b0;
      end else if (y != COORD_MAX) begin
        y <= y + COORD_W'(1);
      end
    end else begin
      x <= x_after_c;
    end
  end

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.win_valid <= 1'b0;
      bus.win_data  <= '0;
      bus.win_sof   <= 1'b0;
      bus.win_eol   <= 1'b0;
      bus.win_x     <= '0;
      bus.win_y     <= '0;
      frame_done    <= 1'b0;
    end else begin
      bus.win_valid <= in_win_c;
      frame_done    <= frame_done_c;
      if (in_win_c) begin
        bus.win_data <= bus.pix_data;
        bus.win_x    <= x - X_LO;
        bus.win_y    <= y - Y_LO;
        bus.win_sof  <= (x == X_LO) && (y == Y_LO);
        bus.win_eol  <= (x == X_LAST);
      end
    end
  end

`ifdef OV5640_WINDOW_STATS_EN
  logic line_chk_c;

  // A line is closed by the next href rise or by the frame's vsync rise.
  assign line_chk_c = (state != ST_IDLE) && !first_line && (vs_rise_c || hs_rise_c);

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_lines <= '0;
      stat_err   <= 1'b0;
    end else begin
      if (state == ST_FRAME && vs_rise_c)
        stat_lines <= first_line ? '0 : ((y == COORD_MAX) ? y : y + COORD_W'(1));
      if (line_chk_c && x_after_c != COORD_W'(IMG_W))
        stat_err <= 1'b1;
    end
  end
`else
  assign stat_lines = '0;
  assign stat_err   = 1'b0;
`endif

endmodule
